piece_sequencer: RTL and testbench

//  Supplies Tetris shapes to the game FSM. A 7-bag randomizer guarantees each

---
 rtl/tetris_pkg.sv | 19 +
 rtl/bag_randomizer.sv | 47 ++++
 rtl/piece_sequencer.sv | 72 +++++++
 tb/tb_piece_sequencer.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/tetris_pkg.sv
// tetris_pkg: shared shape codes, FSM states and draw helper for the piece sequencer
package tetris_pkg;
  localparam int SHAPE_W = 3;
  localparam int NUM_SHAPES = 7;
  localparam logic [SHAPE_W-1:0] SHAPE_NONE = 3'd0;
  localparam logic [SHAPE_W-1:0] SHAPE_I = 3'd1;
  localparam logic [SHAPE_W-1:0] SHAPE_O = 3'd2;
  localparam logic [SHAPE_W-1:0] SHAPE_T = 3'd3;
  localparam logic [SHAPE_W-1:0] SHAPE_S = 3'd4;
  localparam logic [SHAPE_W-1:0] SHAPE_Z = 3'd5;
  localparam logic [SHAPE_W-1:0] SHAPE_J = 3'd6;
  localparam logic [SHAPE_W-1:0] SHAPE_L = 3'd7;
  typedef enum logic [1:0] {IDLE, FILL, READY, REFILL} state_t;
  function automatic logic [SHAPE_W-1:0] lowest_shape(input logic [NUM_SHAPES-1:0] mask);
    lowest_shape = SHAPE_NONE;
    for (int i = NUM_SHAPES - 1; i >= 0; i--)
      if (mask[i]) lowest_shape = SHAPE_W'(i + 1);
  endfunction
endpackage

// File: rtl/bag_randomizer.sv
// bag_randomizer: LFSR-driven 7-bag draw, one attempt per cycle, forced pick after 7 rejects
module bag_randomizer import tetris_pkg::*; #(
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               flush,
  input  logic               draw_req,
  output logic               draw_valid,
  output logic [SHAPE_W-1:0] draw_shape
);
  localparam logic [15:0] SEED = (LFSR_SEED == 16'h0000) ? 16'h0001 : LFSR_SEED;
  logic [15:0] lfsr;
  logic [NUM_SHAPES-1:0] bag_mask, cleared, mask_next;
  logic [2:0] retry;
  logic [7:0] slots, sel;
  logic hit;
  // candidate check against the bag; the lowest remaining shape is the fallback
  always_comb begin
    slots = {bag_mask, 1'b0};
    hit = slots[lfsr[2:0]];
    draw_valid = draw_req && !flush && (hit || retry == 3'd7);
    draw_shape = hit ? lfsr[2:0] : lowest_shape(bag_mask);
    sel = 8'b1 << draw_shape;
    cleared = bag_mask & ~sel[7:1];
    mask_next = (cleared == '0) ? 7'h7F : cleared;
  end
  // LFSR free-runs; bag and retry count follow accepted/rejected attempts
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      lfsr <= SEED;
      bag_mask <= 7'h7F;
      retry <= 3'd0;
    end else begin
      lfsr <= {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);
      if (flush) begin
        bag_mask <= 7'h7F;
        retry <= 3'd0;
      end else if (draw_valid) begin
        bag_mask <= mask_next;
        retry <= 3'd0;
      end else if (draw_req) begin
        retry <= retry + 3'd1;
      end
    end
  end
endmodule

// File: rtl/piece_sequencer.sv
// piece_sequencer: preview queue and spawn handshake fed by the 7-bag randomizer
module piece_sequencer import tetris_pkg::*; #(
  parameter int          PREVIEW_DEPTH = 3,
  parameter logic [15:0] LFSR_SEED     = 16'hACE1
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               game_start,
  input  logic                               spawn_req,
  output logic                               spawn_valid,
  output logic [SHAPE_W-1:0]                 spawn_shape,
  output logic [SHAPE_W*PREVIEW_DEPTH-1:0]   preview_shapes,
  output logic                               ready
);
  localparam int CW = $clog2(PREVIEW_DEPTH + 2);
  localparam logic [CW-1:0] LAST = CW'(PREVIEW_DEPTH);
  state_t state, state_next;
  logic [CW-1:0] count;
  logic [SHAPE_W-1:0] queue [PREVIEW_DEPTH+1];
  logic draw_req, draw_valid, spawn_go;
  logic [SHAPE_W-1:0] draw_shape;

  bag_randomizer #(.LFSR_SEED(LFSR_SEED)) u_bag (
    .clk(clk),
    .rst_n(rst_n),
    .flush(game_start),
    .draw_req(draw_req),
    .draw_valid(draw_valid),
    .draw_shape(draw_shape)
  );

  // game_start overrides everything; READY is left only by a spawn, FILL/REFILL by a draw
  always_comb begin
    draw_req = !game_start && (state == FILL || state == REFILL);
    spawn_go = !game_start && state == READY && spawn_req;
    state_next = game_start ? FILL :
                 spawn_go ? REFILL :
                 (draw_valid && (state == REFILL || count == LAST)) ? READY : state;
    ready = state == READY;
  end

  // state, spawn pulse and queue: flush, shift on spawn, append at the tail on draw
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      count <= '0;
      spawn_valid <= 1'b0;
      spawn_shape <= SHAPE_NONE;
      for (int i = 0; i <= PREVIEW_DEPTH; i++) queue[i] <= SHAPE_NONE;
    end else begin
      state <= state_next;
      spawn_valid <= spawn_go;
      if (game_start) begin
        count <= '0;
        for (int i = 0; i <= PREVIEW_DEPTH; i++) queue[i] <= SHAPE_NONE;
      end else if (spawn_go) begin
        spawn_shape <= queue[0];
        for (int i = 0; i < PREVIEW_DEPTH; i++) queue[i] <= queue[i+1];
        queue[PREVIEW_DEPTH] <= SHAPE_NONE;
        count <= count - CW'(1);
      end else if (draw_valid) begin
        for (int i = 0; i <= PREVIEW_DEPTH; i++)
          if (count == CW'(i)) queue[i] <= draw_shape;
        count <= count + CW'(1);
      end
    end
  end

  for (genvar i = 0; i < PREVIEW_DEPTH; i++) begin : g_prev
    assign preview_shapes[i*SHAPE_W +: SHAPE_W] = queue[i+1];
  end
endmodule

// File: tb/tb_piece_sequencer.sv
// tb_piece_sequencer: directed checks of fill, bag, handshake, restart and a 16-seed draw sweep
module tb_piece_sequencer;
  localparam int D = 3;
  logic clk = 0, rst_n = 0, game_start = 0, spawn_req = 0;
  logic spawn_valid, ready;
  logic [2:0] spawn_shape;
  logic [3*D-1:0] preview_shapes;
  logic sw_start = 0, sw_req = 0, sw_mon = 0;
  logic [15:0] sw_valid, sw_ready;
  logic [2:0] sw_shape [16];
  logic [3*D-1:0] sw_prev [16];
  int sw_gap [16], sw_max [16], sw_n [16], sw_err [16];
  logic [7:0] sw_seen [16];
  int passed = 0, total = 0;

  always #5 clk = ~clk;

  piece_sequencer #(.PREVIEW_DEPTH(D), .LFSR_SEED(16'hACE1)) dut (
    .clk(clk), .rst_n(rst_n), .game_start(game_start), .spawn_req(spawn_req),
    .spawn_valid(spawn_valid), .spawn_shape(spawn_shape),
    .preview_shapes(preview_shapes), .ready(ready)
  );

  for (genvar i = 0; i < 16; i++) begin : g_sw
    piece_sequencer #(.PREVIEW_DEPTH(D), .LFSR_SEED(16'(i * 4099))) u (
      .clk(clk), .rst_n(rst_n), .game_start(sw_start), .spawn_req(sw_req),
      .spawn_valid(sw_valid[i]), .spawn_shape(sw_shape[i]),
      .preview_shapes(sw_prev[i]), .ready(sw_ready[i])
    );
  end

  // per-seed record of spawn spacing and bag completeness
  always @(negedge clk) begin
    if (sw_mon)
      for (int i = 0; i < 16; i++) begin
        sw_gap[i]++;
        if (sw_valid[i]) begin
          if (sw_gap[i] > sw_max[i]) sw_max[i] = sw_gap[i];
          sw_gap[i] = 0;
          if (sw_shape[i] == 3'd0 || sw_seen[i][sw_shape[i]]) sw_err[i]++;
          sw_seen[i][sw_shape[i]] = 1'b1;
          sw_n[i]++;
          if (sw_n[i] % 7 == 0) begin
            if (sw_seen[i] != 8'hFE) sw_err[i]++;
            sw_seen[i] = 8'h00;
          end
        end
      end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready(input int lim, output bit ok);
    ok = ready;
    for (int i = 0; i < lim && !ok; i++) begin
      tick();
      ok = ready;
    end
  endtask

  task automatic do_spawn(output logic [2:0] sh, output bit ok);
    ok = 0;
    sh = 3'd0;
    spawn_req = 1;
    for (int i = 0; i < 12 && !ok; i++) begin
      tick();
      if (spawn_valid) begin
        ok = 1;
        sh = spawn_shape;
      end
    end
    spawn_req = 0;
  endtask

  task automatic start_game;
    game_start = 1;
    tick();
    game_start = 0;
  endtask

  task automatic test_reset;
    int bad = 0;
    rst_n = 0;
    repeat (3) tick();
    total++; if (spawn_valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", spawn_valid); else passed++;
    total++; if (spawn_shape !== 3'd0) $display("FAIL reset_shape: got %0d want 0", spawn_shape); else passed++;
    total++; if (preview_shapes !== '0) $display("FAIL reset_preview: got %h want 0", preview_shapes); else passed++;
    total++; if (ready !== 1'b0) $display("FAIL reset_ready: got %b want 0", ready); else passed++;
    rst_n = 1;
    spawn_req = 1;
    repeat (5) begin
      tick();
      if (spawn_valid !== 1'b0 || ready !== 1'b0) bad++;
    end
    spawn_req = 0;
    total++; if (bad != 0) $display("FAIL idle_no_spawn: got %0d bad cycles want 0", bad); else passed++;
  endtask

  task automatic check_full_preview(input string tag);
    logic [2:0] a, b, c;
    a = preview_shapes[2:0];
    b = preview_shapes[5:3];
    c = preview_shapes[8:6];
    total++; if (a == 0 || b == 0 || c == 0) $display("FAIL %s_range: got %0d %0d %0d want 1..7", tag, a, b, c); else passed++;
    total++; if (a == b || b == c || a == c) $display("FAIL %s_distinct: got %0d %0d %0d want distinct", tag, a, b, c); else passed++;
  endtask

  task automatic test_fill;
    bit ok;
    start_game();
    wait_ready(34, ok);
    total++; if (!ok) $display("FAIL fill_ready: got ready=%b want 1 within 34 cycles", ready); else passed++;
    check_full_preview("fill");
  endtask

  task automatic test_handshake;
    logic [8:0] pv;
    logic [2:0] sh;
    bit ok;
    int n = 0;
    total++; if (ready !== 1'b1) $display("FAIL hs_ready: got %b want 1", ready); else passed++;
    pv = preview_shapes;
    spawn_req = 1;
    tick();
    total++; if (spawn_valid !== 1'b1) $display("FAIL hs_latency: got valid=%b want 1", spawn_valid); else passed++;
    total++; if (preview_shapes !== {3'd0, pv[8:3]}) $display("FAIL hs_shift: got %h want %h", preview_shapes, {3'd0, pv[8:3]}); else passed++;
    tick();
    total++; if (spawn_valid !== 1'b0) $display("FAIL hs_pulse_width: got %b want 0", spawn_valid); else passed++;
    ok = 0;
    sh = 3'd0;
    for (int i = 0; i < 12 && !ok; i++) begin
      tick();
      if (spawn_valid) begin
        ok = 1;
        sh = spawn_shape;
      end
    end
    spawn_req = 0;
    total++; if (!ok) $display("FAIL hs_second_pulse: got none want 1"); else passed++;
    total++; if (sh !== pv[2:0]) $display("FAIL hs_head: got %0d want %0d", sh, pv[2:0]); else passed++;
    repeat (12) begin
      tick();
      if (spawn_valid) n++;
    end
    total++; if (n != 0) $display("FAIL hs_extra_pulse: got %0d want 0", n); else passed++;
    total++; if (ready !== 1'b1) $display("FAIL hs_ready_again: got %b want 1", ready); else passed++;
  endtask

  task automatic test_bag;
    logic [2:0] sh, nxt = 3'd0, pv;
    logic [7:0] seen = 8'h00;
    bit ok, rdy;
    start_game();
    for (int k = 0; k < 14; k++) begin
      wait_ready(12, rdy);
      total++; if (!rdy) $display("FAIL bag_ready_%0d: got 0 want 1", k); else passed++;
      pv = preview_shapes[2:0];
      do_spawn(sh, ok);
      total++; if (!ok) $display("FAIL bag_spawn_%0d: got no pulse want pulse", k); else passed++;
      if (k > 0) begin
        total++; if (sh !== nxt) $display("FAIL bag_order_%0d: got %0d want %0d", k, sh, nxt); else passed++;
      end
      nxt = pv;
      seen[sh] = 1'b1;
      if (k % 7 == 6) begin
        total++; if (seen !== 8'hFE) $display("FAIL bag_group_%0d: got %h want fe", k / 7, seen); else passed++;
        seen = 8'h00;
      end
    end
    wait_ready(12, rdy);
  endtask

  task automatic test_restart;
    logic [2:0] sh;
    logic [7:0] seen = 8'h00;
    bit ok;
    int bad = 0;
    spawn_req = 1;
    tick();
    spawn_req = 0;
    game_start = 1;
    tick();
    game_start = 0;
    total++; if (preview_shapes !== '0) $display("FAIL rs_preview_clear: got %h want 0", preview_shapes); else passed++;
    total++; if (ready !== 1'b0 || spawn_valid !== 1'b0) $display("FAIL rs_flags: got ready=%b valid=%b want 0 0", ready, spawn_valid); else passed++;
    wait_ready(34, ok);
    total++; if (!ok) $display("FAIL rs_ready: got 0 want 1 within 34 cycles"); else passed++;
    check_full_preview("rs");
    for (int k = 0; k < 7; k++) begin
      wait_ready(12, ok);
      do_spawn(sh, ok);
      seen[sh] = 1'b1;
    end
    total++; if (seen !== 8'hFE) $display("FAIL rs_fresh_bag: got %h want fe", seen); else passed++;
    wait_ready(12, ok);
    spawn_req = 1;
    game_start = 1;
    tick();
    spawn_req = 0;
    game_start = 0;
    total++; if (spawn_valid !== 1'b0 || preview_shapes !== '0) $display("FAIL rs_start_wins: got valid=%b preview=%h want 0 0", spawn_valid, preview_shapes); else passed++;
    repeat (2) tick();
    rst_n = 0;
    tick();
    rst_n = 1;
    total++; if (ready !== 1'b0 || preview_shapes !== '0 || spawn_valid !== 1'b0 || spawn_shape !== 3'd0)
      $display("FAIL rs_reset_fill: got ready=%b preview=%h valid=%b shape=%0d want all 0", ready, preview_shapes, spawn_valid, spawn_shape); else passed++;
    spawn_req = 1;
    repeat (6) begin
      tick();
      if (spawn_valid !== 1'b0 || ready !== 1'b0 || preview_shapes !== '0) bad++;
    end
    spawn_req = 0;
    total++; if (bad != 0) $display("FAIL rs_idle_after_reset: got %0d bad cycles want 0", bad); else passed++;
  endtask

  task automatic test_sweep;
    for (int i = 0; i < 16; i++) begin
      sw_gap[i] = 0; sw_max[i] = 0; sw_n[i] = 0; sw_err[i] = 0; sw_seen[i] = 8'h00;
    end
    sw_start = 1;
    tick();
    sw_start = 0;
    for (int i = 0; i < 34 && sw_ready != 16'hFFFF; i++) tick();
    for (int i = 0; i < 16; i++) begin
      total++; if (sw_ready[i] !== 1'b1) $display("FAIL sweep_fill_%0d: got ready=%b want 1", i, sw_ready[i]); else passed++;
    end
    sw_mon = 1;
    sw_req = 1;
    repeat (150) tick();
    sw_req = 0;
    sw_mon = 0;
    for (int i = 0; i < 16; i++) begin
      total++; if (sw_max[i] > 9) $display("FAIL sweep_gap_%0d: got %0d cycles want <= 9", i, sw_max[i]); else passed++;
      total++; if (sw_err[i] != 0) $display("FAIL sweep_bag_%0d: got %0d errors want 0", i, sw_err[i]); else passed++;
      total++; if (sw_n[i] < 14) $display("FAIL sweep_count_%0d: got %0d spawns want >= 14", i, sw_n[i]); else passed++;
    end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_handshake();
    test_bag();
    test_restart();
    test_sweep();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
